uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 35 +++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmitter/receiver pair.
//   - RX state encodings (3-bit, legacy-compatible localparams)
//   - default CLKS_PER_BIT (clock frequency / baud)
//   - data width of one UART character
// No ports; imported with "import uart_pkg::*;".
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int DATA_W               = 8;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE      = 3'd0;
  localparam rx_state_t RX_START     = 3'd1;
  localparam rx_state_t RX_DATA      = 3'd2;
  localparam rx_state_t RX_STOP      = 3'd3;
  localparam rx_state_t RX_CLEANUP   = 3'd4;
  localparam rx_state_t RX_WAIT_HIGH = 3'd5;

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous bit.
// Parameters:
//   RESET_VAL  value both flops load during reset
// Ports:
//   i_Clock    sole clock
//   i_Rst_n    synchronous active-low reset
//   async_bit  asynchronous input
//   sync_bit   synchronised output (second flop), 2 clocks of latency
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic meta;

  // Both stages reset to RESET_VAL so that an idle-high line does not
  // present a transient edge to downstream logic when reset is released.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      meta     <= RESET_VAL;
      sync_bit <= RESET_VAL;
    end else begin
      meta     <= async_bit;
      sync_bit <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Synchronises the serial line, qualifies the start bit at
// its centre, samples 8 data bits LSB first at bit centres and checks the
// stop bit. Good bytes are reported with a one-cycle o_Rx_DV pulse, bad stop
// bits with a one-cycle o_Rx_Frame_Err pulse.
// Parameters:
//   CLKS_PER_BIT     clock frequency / baud, legal range 4..1023
// Ports:
//   i_Clock          sole clock
//   i_Rst_n          synchronous active-low reset
//   i_Rx_Serial      asynchronous serial line, idle high
//   o_Rx_DV          one-cycle pulse, o_Rx_Byte holds a new valid byte
//   o_Rx_Byte        last good byte, held between pulses
//   o_Rx_Frame_Err   one-cycle pulse, stop bit sampled low
//   o_Rx_Active      high while a frame is being received
//   o_Rx_Break       (only with UART_RX_BREAK_DETECT_EN) one-cycle pulse
//                    alongside o_Rx_Frame_Err when data and stop were all 0
// Build option: define UART_RX_BREAK_DETECT_EN to add line-break detection.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_Serial,
  output logic              o_Rx_DV,
  output logic [DATA_W-1:0] o_Rx_Byte,
  output logic              o_Rx_Frame_Err,
  output logic              o_Rx_Active
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic              o_Rx_Break
`endif
);

  localparam logic [9:0] HALF_BIT = 10'((CLKS_PER_BIT - 1) / 2);
  localparam logic [9:0] FULL_BIT = 10'(CLKS_PER_BIT - 1);

  logic              rx_s;
  rx_state_t         state;
  logic [9:0]        clk_count;
  logic [2:0]        bit_index;
  logic [DATA_W-1:0] rx_byte;

  // Every receiver decision is taken on the synchronised line only.
  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .async_bit (i_Rx_Serial),
    .sync_bit  (rx_s)
  );

  // Receive state machine. Data bits are assembled in rx_byte and only copied
  // to o_Rx_Byte once the stop bit is confirmed high, so the output never
  // shows a partially received or framing-bad character. The DV/error pulses
  // default low every cycle and are raised for exactly one cycle in STOP.
  // WAIT_HIGH swallows a line that stays low after a bad stop bit so it
  // cannot be mistaken for a fresh start bit.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state          <= RX_IDLE;
      clk_count      <= '0;
      bit_index      <= '0;
      rx_byte        <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= '0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      o_Rx_Break     <= 1'b0;
`endif
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      o_Rx_Break     <= 1'b0;
`endif
      case (state)
        RX_IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          if (!rx_s) begin
            state       <= RX_START;
            o_Rx_Active <= 1'b1;
          end
        end

        RX_START: begin
          if (clk_count == HALF_BIT) begin
            clk_count <= '0;
            if (!rx_s) begin
              state <= RX_DATA;
            end else begin
              state       <= RX_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 10'd1;
          end
        end

        RX_DATA: begin
          if (clk_count < FULL_BIT) begin
            clk_count <= clk_count + 10'd1;
          end else begin
            clk_count          <= '0;
            rx_byte[bit_index] <= rx_s;
            if (bit_index == 3'd7) begin
              bit_index <= '0;
              state     <= RX_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end
        end

        RX_STOP: begin
          if (clk_count < FULL_BIT) begin
            clk_count <= clk_count + 10'd1;
          end else begin
            clk_count <= '0;
            if (rx_s) begin
              o_Rx_Byte <= rx_byte;
              o_Rx_DV   <= 1'b1;
              state     <= RX_CLEANUP;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
              o_Rx_Break     <= (rx_byte == '0);
`endif
              state          <= RX_WAIT_HIGH;
            end
          end
        end

        RX_CLEANUP: begin
          o_Rx_Active <= 1'b0;
          state       <= RX_IDLE;
        end

        RX_WAIT_HIGH: begin
          o_Rx_Active <= 1'b0;
          if (rx_s) begin
            state <= RX_IDLE;
          end
        end

        default: begin
          o_Rx_Active <= 1'b0;
          clk_count   <= '0;
          bit_index   <= '0;
          state       <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx with CLKS_PER_BIT = 16. The serial line is
// generated by the bench itself (frames are driven on falling clock edges,
// outputs observed on falling edges). Define UART_RX_BREAK_DETECT_EN to
// include the line-break scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       active;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       brk;
`endif

  int vecs;
  int miscompares;

  int dv_count;
  int fe_count;
  int active_cycles;
  int both_count;
  int brk_count;
  int brk_fe_count;
  logic [7:0] dv_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (frame_err),
    .o_Rx_Active    (active)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .o_Rx_Break     (brk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: tallies output pulses and captures every delivered byte.
  always @(negedge clk) begin
    if (dv) begin
      dv_count = dv_count + 1;
      dv_q.push_back(rx_byte);
    end
    if (frame_err) fe_count = fe_count + 1;
    if (active) active_cycles = active_cycles + 1;
    if (dv && frame_err) both_count = both_count + 1;
`ifdef UART_RX_BREAK_DETECT_EN
    if (brk) brk_count = brk_count + 1;
    if (brk && frame_err) brk_fe_count = brk_fe_count + 1;
`endif
  end

  // Drives one 8N1 frame. period2 is the bit period in half clocks, so 32 is
  // nominal, 31/33 are about -3%/+3% and 34 is 17 clocks per bit. The line is
  // left at the stop-bit value on return.
  task automatic send_frame(input logic [7:0] b, input int period2, input logic stop_bit);
    int cyc;
    int end_c;
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    cyc = 0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      end_c = (period2 * (k + 1)) / 2;
      while (cyc < end_c) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if (dv !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dv: got %b want 0", dv); end
    vecs++; if (rx_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_byte: got %h want 00", rx_byte); end
    vecs++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fe: got %b want 0", frame_err); end
    vecs++; if (active !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_active: got %b want 0", active); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vecs++; if (active_cycles !== 0) begin miscompares++; $display("[TB] FAIL reset_release_start: active cycles %0d want 0", active_cycles); end
  endtask

  task automatic test_loopback();
    int dv_base;
    int fe_base;
    logic [7:0] exp_b[4];
    exp_b = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    dv_base = dv_count;
    fe_base = fe_count;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 32, 1'b1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    vecs++;
    if (dv_count - dv_base !== 4) begin
      miscompares++; $display("[TB] FAIL loopback_count: got %0d pulses want 4", dv_count - dv_base);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (dv_base + i >= dv_q.size()) begin
        miscompares++; $display("[TB] FAIL loopback_byte%0d: missing want %h", i, exp_b[i]);
      end else if (dv_q[dv_base + i] !== exp_b[i]) begin
        miscompares++; $display("[TB] FAIL loopback_byte%0d: got %h want %h", i, dv_q[dv_base + i], exp_b[i]);
      end
    end
    vecs++; if (fe_count - fe_base !== 0) begin miscompares++; $display("[TB] FAIL loopback_fe: got %0d want 0", fe_count - fe_base); end
    vecs++; if (rx_byte !== 8'h3C) begin miscompares++; $display("[TB] FAIL loopback_hold: got %h want 3c", rx_byte); end
  endtask

  // Falling edge at negedge n0 reaches the IDLE decision 3 clocks later,
  // START then takes 7+1 clocks and 9 full bits follow: DV is seen 155
  // falling edges after the line fell.
  task automatic test_latency();
    int n;
    n = 0;
    fork
      send_frame(8'h5A, 32, 1'b1);
      begin
        @(negedge clk);
        while (dv !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        vecs++;
        if (n < 154 || n > 156) begin
          miscompares++; $display("[TB] FAIL latency: got %0d clocks want 155 +-1", n);
        end
        vecs++; if (rx_byte !== 8'h5A) begin miscompares++; $display("[TB] FAIL latency_byte: got %h want 5a", rx_byte); end
        @(negedge clk);
        vecs++; if (dv !== 1'b0) begin miscompares++; $display("[TB] FAIL dv_one_cycle: got %b want 0", dv); end
      end
    join
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    int dv_base;
    int fe_base;
    int act_base;
    dv_base  = dv_count;
    fe_base  = fe_count;
    act_base = active_cycles;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    vecs++; if (dv_count - dv_base !== 0) begin miscompares++; $display("[TB] FAIL glitch_dv: got %0d want 0", dv_count - dv_base); end
    vecs++; if (fe_count - fe_base !== 0) begin miscompares++; $display("[TB] FAIL glitch_fe: got %0d want 0", fe_count - fe_base); end
    vecs++;
    if (active_cycles - act_base < 1 || active_cycles - act_base > 10) begin
      miscompares++; $display("[TB] FAIL glitch_active: got %0d cycles want 1..10", active_cycles - act_base);
    end
  endtask

  task automatic test_frame_error();
    int dv_base;
    int fe_base;
    int brk_base;
    dv_base  = dv_count;
    fe_base  = fe_count;
    brk_base = brk_count;
    send_frame(8'h55, 32, 1'b0);
    repeat (40) @(negedge clk);
    vecs++; if (fe_count - fe_base !== 1) begin miscompares++; $display("[TB] FAIL ferr_pulse: got %0d want 1", fe_count - fe_base); end
    vecs++; if (dv_count - dv_base !== 0) begin miscompares++; $display("[TB] FAIL ferr_dv: got %0d want 0", dv_count - dv_base); end
    vecs++; if (rx_byte !== 8'h5A) begin miscompares++; $display("[TB] FAIL ferr_hold: got %h want 5a", rx_byte); end
    vecs++; if (active !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_no_restart: active %b want 0", active); end
    vecs++; if (brk_count - brk_base !== 0) begin miscompares++; $display("[TB] FAIL ferr_no_break: got %0d want 0", brk_count - brk_base); end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h12, 32, 1'b1);
    repeat (20) @(negedge clk);
    vecs++; if (dv_count - dv_base !== 1) begin miscompares++; $display("[TB] FAIL ferr_next_dv: got %0d want 1", dv_count - dv_base); end
    vecs++; if (rx_byte !== 8'h12) begin miscompares++; $display("[TB] FAIL ferr_next_byte: got %h want 12", rx_byte); end
    vecs++; if (fe_count - fe_base !== 1) begin miscompares++; $display("[TB] FAIL ferr_once: got %0d want 1", fe_count - fe_base); end
  endtask

  // Reset lands mid-frame once bit 3 has long been sampled, during bit 6 of
  // 8'hC3. Bits 6, 7 and the stop bit are high, so after release nothing can
  // look like a start bit; releasing on a low data bit would legitimately
  // begin a bogus frame.
  task automatic test_reset_midframe();
    int dv_base;
    int act_base;
    dv_base  = dv_count;
    act_base = 0;
    fork
      send_frame(8'hC3, 32, 1'b1);
      begin
        @(negedge clk);
        repeat (120) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vecs++; if (dv !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_dv: got %b want 0", dv); end
        vecs++; if (rx_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_byte: got %h want 00", rx_byte); end
        vecs++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_fe: got %b want 0", frame_err); end
        vecs++; if (active !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_active: got %b want 0", active); end
        rst_n = 1'b1;
        act_base = active_cycles;
      end
    join
    rx = 1'b1;
    repeat (40) @(negedge clk);
    vecs++; if (dv_count - dv_base !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_dv: got %0d want 0", dv_count - dv_base); end
    vecs++; if (active_cycles - act_base !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_start: got %0d active cycles want 0", active_cycles - act_base); end
    send_frame(8'h81, 32, 1'b1);
    repeat (20) @(negedge clk);
    vecs++; if (dv_count - dv_base !== 1) begin miscompares++; $display("[TB] FAIL midrst_next_dv: got %0d want 1", dv_count - dv_base); end
    vecs++; if (rx_byte !== 8'h81) begin miscompares++; $display("[TB] FAIL midrst_next_byte: got %h want 81", rx_byte); end
  endtask

  // Baud skew: 17 clocks/bit, and a line averaging 15.5 / 16.5 clocks/bit
  // (about -3% / +3%). A flat 15 clocks/bit is -6.25% and, with the
  // synchroniser's extra latency, drifts out of bit 5 by the late bits.
  task automatic test_skew();
    int dv_base;
    int p2[3];
    p2 = '{34, 31, 33};
    for (int i = 0; i < 3; i++) begin
      dv_base = dv_count;
      send_frame(8'h96, p2[i], 1'b1);
      repeat (40) @(negedge clk);
      vecs++; if (dv_count - dv_base !== 1) begin miscompares++; $display("[TB] FAIL skew%0d_dv: got %0d want 1", p2[i], dv_count - dv_base); end
      vecs++; if (rx_byte !== 8'h96) begin miscompares++; $display("[TB] FAIL skew%0d_byte: got %h want 96", p2[i], rx_byte); end
    end
  endtask

`ifdef UART_RX_BREAK_DETECT_EN
  task automatic test_break();
    int dv_base;
    int fe_base;
    int brk_base;
    int both_base;
    dv_base   = dv_count;
    fe_base   = fe_count;
    brk_base  = brk_count;
    both_base = brk_fe_count;
    @(negedge clk);
    rx = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    vecs++; if (brk_count - brk_base !== 1) begin miscompares++; $display("[TB] FAIL break_pulse: got %0d want 1", brk_count - brk_base); end
    vecs++; if (fe_count - fe_base !== 1) begin miscompares++; $display("[TB] FAIL break_fe: got %0d want 1", fe_count - fe_base); end
    vecs++; if (brk_fe_count - both_base !== 1) begin miscompares++; $display("[TB] FAIL break_together: got %0d want 1", brk_fe_count - both_base); end
    vecs++; if (dv_count - dv_base !== 0) begin miscompares++; $display("[TB] FAIL break_dv: got %0d want 0", dv_count - dv_base); end
  endtask
`endif

  task automatic test_exclusive();
    vecs++; if (both_count !== 0) begin miscompares++; $display("[TB] FAIL dv_fe_overlap: got %0d cycles want 0", both_count); end
  endtask

  initial begin
    vecs          = 0;
    miscompares   = 0;
    dv_count      = 0;
    fe_count      = 0;
    active_cycles = 0;
    both_count    = 0;
    brk_count     = 0;
    brk_fe_count  = 0;
    rst_n         = 1'b0;
    rx            = 1'b1;
    test_reset();
    test_loopback();
    test_latency();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_skew();
`ifdef UART_RX_BREAK_DETECT_EN
    test_break();
`endif
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
